// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, WIDTH shifts per conversion.
// Result digits are latched only on completion, so intermediate scratch values never reach the outputs.

module bcd_dig_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_seq_converter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       d0,
  output logic [3:0]       d1,
  output logic [3:0]       d2
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [11:0]      scr, scr_adj, scr_nxt;
  logic [CW-1:0]    cnt;
  logic             last_shift;

  // One add-3 adjuster per BCD digit of the scratch register
  for (genvar g = 0; g < 3; g++) begin : g_adj
    bcd_dig_adj u_adj (
      .din  (scr[4*g +: 4]),
      .dout (scr_adj[4*g +: 4])
    );
  end

  assign scr_nxt    = {scr_adj[10:0], sreg[WIDTH-1]};
  assign last_shift = (cnt == CW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      scr   <= '0;
      cnt   <= '0;
      d0    <= '0;
      d1    <= '0;
      d2    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          sreg <= bin;
          scr  <= '0;
          cnt  <= CW'(WIDTH);
        end
        SHIFT: begin
          scr  <= scr_nxt;
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          cnt  <= cnt - CW'(1);
          if (last_shift) begin
            d0 <= scr_nxt[3:0];
            d1 <= scr_nxt[7:4];
            d2 <= scr_nxt[11:8];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: doc/bcd_seq_converter.md
BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter WIDTH, default 8, binary input width; legal range 4..9, so the maximum value is 511 and fits in 3 BCD digits.
REQ-002 Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 Start  input  1  request a conversion of Bin; sampled only in IDLE.
REQ-005 Bin  input  WIDTH  unsigned binary value to convert; captured on the accepting edge.
REQ-006 Busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-007 Done  output  1  one-cycle pulse; result valid on D0..D2.
REQ-008 D0  output  4  BCD ones digit of the last completed conversion.
REQ-009 D1  output  4  BCD tens digit.
REQ-010 D2  output  4  BCD hundreds digit.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE; illegal encodings SHALL return to IDLE on the next edge.
REQ-012 IDLE: Start=1 at an edge SHALL capture Bin into a WIDTH-bit shift register, clear a 12-bit BCD scratch register, load the shift counter with WIDTH, and enter SHIFT; Start=0 stays in IDLE.
REQ-013 SHIFT, each edge: every scratch digit >= 5 gets +3 (4-bit, no carry out), then {scratch, shiftreg} shifts left 1, the shift-register MSB enters scratch bit 0, and the counter decrements.
REQ-014 The edge performing the WIDTH-th shift SHALL load D0/D1/D2 from the post-shift scratch value and enter DONE.
REQ-015 DONE: Done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-016 Busy SHALL be 1 exactly in SHIFT; Done SHALL be 1 exactly in DONE; both are decoded from registered state (no combinational path from Start).
REQ-017 Latency: Start accepted at edge N -> Busy high cycles N..N+WIDTH-1, Done high in the cycle after edge N+WIDTH.
REQ-018 Start SHALL be ignored in SHIFT and DONE: no restart and no capture of Bin.
REQ-019 Minimum spacing between accepted Starts is WIDTH+2 edges; Start held high continuously yields back-to-back conversions at that rate.
REQ-020 Bin changes after the accepting edge SHALL NOT affect the result.
REQ-021 D0..D2 SHALL hold the previous result until the next transition into DONE; they SHALL NOT expose intermediate scratch values.
REQ-022 Each output digit SHALL always be in 0..9; D2 <= 5 for all legal WIDTH.

Reset
REQ-023 Reset=1 at an edge SHALL force state IDLE, Busy=0, Done=0, D0=D1=D2=0, and clear the counter, scratch and shift registers, regardless of state.
REQ-024 Reset SHALL take priority over Start; Reset asserted mid-SHIFT aborts the conversion with no Done pulse and outputs cleared.
REQ-025 The first Start after Reset deasserts SHALL be accepted normally.

Verification
REQ-026 WIDTH=8, Bin=255, Start pulsed at edge N -> Busy cycles N..N+7, Done in the cycle after edge N+8, D2=2 D1=5 D0=5.
REQ-027 WIDTH=8, sweep Bin 0..255 -> each result equals the decimal digits of Bin (Bin=0 -> 0,0,0; Bin=99 -> 0,9,9; Bin=100 -> 1,0,0).
REQ-028 WIDTH=8, Bin=37 accepted, then Start=1 with Bin=200 during SHIFT -> single Done, result 0,3,7; the outputs keep 0,3,7 afterwards.
REQ-029 WIDTH=8, Reset asserted 3 cycles into a conversion of Bin=128 -> no Done, outputs 0,0,0, state IDLE; next Start with Bin=64 -> 0,6,4.
REQ-030 WIDTH=4, Start held high, Bin=15 then 9 -> Done every 6 cycles; results 0,1,5 then 0,0,9.
REQ-031 WIDTH=9, Bin=511 -> 5,1,1 in the cycle after edge N+9.
